mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle around mem_arbiter: Fetch port, Memory-stage port and the single memory port.
// slave is the arbiter's view; master is the view of the Fetch/Memory stages and the memory.
interface mem_arbiter_if;
    logic [31:0] i_address;
    logic        i_request;
    logic        i_flush;
    logic [31:0] i_data;
    logic        i_valid;

    logic [31:0] d_address;
    logic [31:0] storeData;
    logic [3:0]  byteEnable;
    logic        storeValid;
    logic        loadRequest;
    logic [31:0] loadData;
    logic        loadDataValid;
    logic        storeComplete;

    logic [31:0] m_address;
    logic [31:0] m_writeData;
    logic [3:0]  m_byteEnable;
    logic        m_write;
    logic        m_request;
    logic        m_ready;
    logic [31:0] m_readData;
    logic        m_responseValid;
    logic        busError;

    modport slave (
        input  i_address, i_request, i_flush,
               d_address, storeData, byteEnable, storeValid, loadRequest,
               m_ready, m_readData, m_responseValid,
        output i_data, i_valid, loadData, loadDataValid, storeComplete,
               m_address, m_writeData, m_byteEnable, m_write, m_request, busError
    );

    modport master (
        output i_address, i_request, i_flush,
               d_address, storeData, byteEnable, storeValid, loadRequest,
               m_ready, m_readData, m_responseValid,
        input  i_data, i_valid, loadData, loadDataValid, storeComplete,
               m_address, m_writeData, m_byteEnable, m_write, m_request, busError
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the load/store side, one transaction in flight.
// Define ARBITER_ROUND_ROBIN_EN for alternating grants; otherwise the data side has fixed priority.
module mem_arbiter #(
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int unsigned    CW       = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE_I, WAIT_I, ISSUE_D, WAIT_D} state_e;

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          store_q, store_d;
    logic          flushed_q, flushed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   i_data_q, i_data_d, load_data_q, load_data_d;
    logic          i_valid_q, i_valid_d, load_valid_q, load_valid_d;
    logic          store_done_q, store_done_d, bus_error_q, bus_error_d;
    logic          m_request, m_write;
    logic          data_pend, fetch_pend, grant_data, grant_fetch, timeout;

    // A side whose completion pulse is showing has not yet had the chance to drop its request.
    assign data_pend  = (bus.storeValid || bus.loadRequest)
                        && !(load_valid_q || store_done_q || bus_error_q);
    assign fetch_pend = bus.i_request && !bus.i_flush && !(i_valid_q || bus_error_q);

`ifdef ARBITER_ROUND_ROBIN_EN
    logic last_data_q;

    assign grant_data = data_pend && !(fetch_pend && last_data_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            last_data_q <= 1'b1;
        else if (state_q == IDLE && (data_pend || fetch_pend))
            last_data_q <= grant_data;
    end
`else
    assign grant_data = data_pend;
`endif

    assign grant_fetch = fetch_pend && !grant_data;
    assign timeout     = (cnt_q == CNT_LAST) && !bus.m_responseValid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_data)       state_d = ISSUE_D;
                else if (grant_fetch) state_d = ISSUE_I;
            end
            ISSUE_I: begin
                if (bus.i_flush)      state_d = IDLE;
                else if (bus.m_ready) state_d = WAIT_I;
            end
            ISSUE_D:          if (bus.m_ready) state_d = WAIT_D;
            WAIT_I, WAIT_D:   if (bus.m_responseValid || timeout) state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        store_d      = store_q;
        flushed_d    = flushed_q;
        cnt_d        = cnt_q;
        i_data_d     = i_data_q;
        load_data_d  = load_data_q;
        i_valid_d    = 1'b0;
        load_valid_d = 1'b0;
        store_done_d = 1'b0;
        bus_error_d  = 1'b0;
        m_request    = 1'b0;
        m_write      = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    addr_d  = bus.d_address;
                    wdata_d = bus.storeData;
                    be_d    = bus.byteEnable;
                    store_d = bus.storeValid;
                end else if (grant_fetch) begin
                    addr_d  = bus.i_address;
                    wdata_d = '0;
                    be_d    = 4'hF;
                    store_d = 1'b0;
                end
            end
            ISSUE_I: begin
                m_request = !bus.i_flush;
                cnt_d     = '0;
                flushed_d = 1'b0;
            end
            ISSUE_D: begin
                m_request = 1'b1;
                m_write   = store_q;
                cnt_d     = '0;
            end
            WAIT_I: begin
                cnt_d     = cnt_q + CW'(1);
                flushed_d = flushed_q || bus.i_flush;
                if (bus.m_responseValid) begin
                    if (!(flushed_q || bus.i_flush)) begin
                        i_valid_d = 1'b1;
                        i_data_d  = bus.m_readData;
                    end
                end else if (timeout) begin
                    bus_error_d = 1'b1;
                end
            end
            WAIT_D: begin
                cnt_d = cnt_q + CW'(1);
                if (bus.m_responseValid) begin
                    if (store_q) begin
                        store_done_d = 1'b1;
                    end else begin
                        load_valid_d = 1'b1;
                        load_data_d  = bus.m_readData;
                    end
                end else if (timeout) begin
                    bus_error_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            store_q      <= 1'b0;
            flushed_q    <= 1'b0;
            cnt_q        <= '0;
            i_data_q     <= '0;
            load_data_q  <= '0;
            i_valid_q    <= 1'b0;
            load_valid_q <= 1'b0;
            store_done_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            store_q      <= store_d;
            flushed_q    <= flushed_d;
            cnt_q        <= cnt_d;
            i_data_q     <= i_data_d;
            load_data_q  <= load_data_d;
            i_valid_q    <= i_valid_d;
            load_valid_q <= load_valid_d;
            store_done_q <= store_done_d;
            bus_error_q  <= bus_error_d;
        end
    end

    assign bus.m_request     = m_request;
    assign bus.m_write       = m_write;
    assign bus.m_address     = addr_q;
    assign bus.m_writeData   = wdata_q;
    assign bus.m_byteEnable  = be_q;
    assign bus.i_data        = i_data_q;
    assign bus.i_valid       = i_valid_q;
    assign bus.loadData      = load_data_q;
    assign bus.loadDataValid = load_valid_q;
    assign bus.storeComplete = store_done_q;
    assign bus.busError      = bus_error_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: memory model plus scoreboards of expected accesses and pulses.
module tb_mem_arbiter;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        write;
    } acc_t;

    typedef struct {
        logic [3:0]  kind;   // {i_valid, loadDataValid, storeComplete, busError}
        logic [31:0] data;
    } pulse_t;

    localparam logic [3:0] K_IV = 4'b1000;
    localparam logic [3:0] K_LD = 4'b0100;
    localparam logic [3:0] K_ST = 4'b0010;
    localparam logic [3:0] K_BE = 4'b0001;

    logic clock;
    logic reset;
    mem_arbiter_if bus ();

    mem_arbiter #(.RESP_TIMEOUT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          req_cyc, acc_cyc, i_done_cyc, d_done_cyc;
    acc_t        exp_mem [$];
    pulse_t      exp_q [$];
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] resp_data = '0;
    int          resp_cnt   = -1;
    int          resp_delay = 0;
    bit          resp_en    = 1'b1;
    bit          late_resp  = 1'b0;
    bit          acc;
    acc_t        e;
    pulse_t      p;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(posedge clock) cyc++;

    // Memory model: samples the request just before the edge, answers resp_delay cycles after acceptance.
    always begin
        @(negedge clock);
        #4;
        acc = (bus.m_request === 1'b1) && (bus.m_ready === 1'b1);
        if (acc) begin
            acc_cyc = cyc + 1;
            check("mem_access_expected", exp_mem.size() != 0, 1);
            if (exp_mem.size() != 0) begin
                e = exp_mem.pop_front();
                check("m_address", bus.m_address, e.addr);
                check("m_write", bus.m_write, e.write);
                if (e.write) begin
                    check("m_writeData", bus.m_writeData, e.wdata);
                    check("m_byteEnable", bus.m_byteEnable, e.be);
                end
            end
            resp_data = mem_model.exists(bus.m_address) ? mem_model[bus.m_address] : 32'h0;
            resp_cnt  = resp_en ? resp_delay : -1;
        end else if (resp_cnt >= 0) begin
            resp_cnt--;
        end
        @(posedge clock);
        #1;
        bus.m_responseValid = (resp_cnt == 0) || late_resp;
        bus.m_readData      = resp_data;
    end

    // Pulse monitor: any completion pulse must be one-hot and match the head of the scoreboard.
    always @(negedge clock) begin
        if ((bus.i_valid | bus.loadDataValid | bus.storeComplete | bus.busError) === 1'b1) begin
            check("pulse_onehot",
                  $countones({bus.i_valid, bus.loadDataValid, bus.storeComplete, bus.busError}), 1);
            check("pulse_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                p = exp_q.pop_front();
                check("pulse_kind",
                      {bus.i_valid, bus.loadDataValid, bus.storeComplete, bus.busError}, p.kind);
                if (p.kind == K_IV)      check("i_data", bus.i_data, p.data);
                else if (p.kind == K_LD) check("loadData", bus.loadData, p.data);
            end
        end
    end

    // Upstream behaviour: each side drops its request once it sees its completion pulse.
    task automatic service(input int budget);
        int n = 0;
        while ((bus.i_request || bus.storeValid || bus.loadRequest) && n < budget) begin
            @(negedge clock);
            n++;
            if (bus.i_valid) begin
                bus.i_request = 1'b0;
                i_done_cyc    = cyc;
            end
            if (bus.loadDataValid || bus.storeComplete || bus.busError) begin
                bus.storeValid  = 1'b0;
                bus.loadRequest = 1'b0;
                d_done_cyc      = cyc;
            end
        end
        check("requests_serviced", {bus.i_request, bus.storeValid, bus.loadRequest}, 0);
        repeat (2) @(negedge clock);
        check("pulse_queue_drained", exp_q.size(), 0);
        check("access_queue_drained", exp_mem.size(), 0);
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] w);
        mem_model[a] = w;
        exp_mem.push_back('{addr: a, wdata: 32'h0, be: 4'h0, write: 1'b0});
        exp_q.push_back('{kind: K_IV, data: w});
        bus.i_address = a;
        bus.i_request = 1'b1;
        req_cyc       = cyc;
        service(20);
        check("fetch_latency", i_done_cyc - req_cyc, 3);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] w, input logic [3:0] kind);
        mem_model[a] = w;
        exp_mem.push_back('{addr: a, wdata: 32'h0, be: 4'h0, write: 1'b0});
        exp_q.push_back('{kind: kind, data: w});
        bus.d_address   = a;
        bus.byteEnable  = 4'hF;
        bus.loadRequest = 1'b1;
        service(20);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_m_request"}, bus.m_request, 0);
        check({tag, "_m_write"}, bus.m_write, 0);
        check({tag, "_m_address"}, bus.m_address, 0);
        check({tag, "_m_writeData"}, bus.m_writeData, 0);
        check({tag, "_m_byteEnable"}, bus.m_byteEnable, 0);
        check({tag, "_i_data"}, bus.i_data, 0);
        check({tag, "_loadData"}, bus.loadData, 0);
        check({tag, "_pulses"},
              {bus.i_valid, bus.loadDataValid, bus.storeComplete, bus.busError}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset               = 1'b1;
        bus.i_address       = '0;
        bus.i_request       = 1'b0;
        bus.i_flush         = 1'b0;
        bus.d_address       = '0;
        bus.storeData       = '0;
        bus.byteEnable      = '0;
        bus.storeValid      = 1'b0;
        bus.loadRequest     = 1'b0;
        bus.m_ready         = 1'b1;
        bus.m_readData      = '0;
        bus.m_responseValid = 1'b0;
        #7;
        check_outputs_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        // Plain fetch, three-cycle latency
        do_fetch(32'h0000_0100, 32'h0050_0093);

        // Store held off by m_ready while upstream buses change after the grant
        mem_model[32'h2000] = 32'h0;
        exp_mem.push_back('{addr: 32'h2000, wdata: 32'hDEAD_BEEF, be: 4'h3, write: 1'b1});
        exp_q.push_back('{kind: K_ST, data: 32'h0});
        bus.m_ready    = 1'b0;
        bus.d_address  = 32'h0000_2000;
        bus.storeData  = 32'hDEAD_BEEF;
        bus.byteEnable = 4'h3;
        bus.storeValid = 1'b1;
        @(negedge clock);
        bus.d_address  = 32'hFFFF_FFFC;
        bus.storeData  = 32'h0;
        bus.byteEnable = 4'hF;
        @(negedge clock);
        bus.m_ready = 1'b1;
        service(20);

        // Load with i_flush asserted throughout: data side unaffected
        bus.i_flush = 1'b1;
        do_load(32'h0000_3000, 32'hCAFE_F00D, K_LD);
        bus.i_flush = 1'b0;

        // Load and fetch pending together
        mem_model[32'h3100] = 32'h1111_2222;
        mem_model[32'h0180] = 32'h3333_4444;
`ifdef ARBITER_ROUND_ROBIN_EN
        exp_mem.push_back('{addr: 32'h0180, wdata: 32'h0, be: 4'h0, write: 1'b0});
        exp_mem.push_back('{addr: 32'h3100, wdata: 32'h0, be: 4'h0, write: 1'b0});
        exp_q.push_back('{kind: K_IV, data: 32'h3333_4444});
        exp_q.push_back('{kind: K_LD, data: 32'h1111_2222});
`else
        exp_mem.push_back('{addr: 32'h3100, wdata: 32'h0, be: 4'h0, write: 1'b0});
        exp_mem.push_back('{addr: 32'h0180, wdata: 32'h0, be: 4'h0, write: 1'b0});
        exp_q.push_back('{kind: K_LD, data: 32'h1111_2222});
        exp_q.push_back('{kind: K_IV, data: 32'h3333_4444});
`endif
        bus.d_address   = 32'h0000_3100;
        bus.loadRequest = 1'b1;
        bus.i_address   = 32'h0000_0180;
        bus.i_request   = 1'b1;
        service(40);

        // Flush while the fetch is still waiting to be accepted: no memory access
        bus.m_ready   = 1'b0;
        bus.i_address = 32'h0000_0480;
        bus.i_request = 1'b1;
        @(negedge clock);
        bus.i_flush   = 1'b1;
        bus.i_request = 1'b0;
        bus.m_ready   = 1'b1;
        @(negedge clock);
        bus.i_flush = 1'b0;
        repeat (3) @(negedge clock);
        check("issue_flush_no_request", bus.m_request, 0);
        check("issue_flush_no_access", exp_mem.size(), 0);

        // Flush during WAIT_I: response consumed, no i_valid
        resp_delay              = 2;
        mem_model[32'h0000_0400] = 32'h1234_5678;
        exp_mem.push_back('{addr: 32'h0400, wdata: 32'h0, be: 4'h0, write: 1'b0});
        bus.i_address = 32'h0000_0400;
        bus.i_request = 1'b1;
        repeat (2) @(negedge clock);
        bus.i_flush   = 1'b1;
        bus.i_request = 1'b0;
        @(negedge clock);
        bus.i_flush = 1'b0;
        repeat (6) @(negedge clock);
        check("wait_flush_no_pulse", exp_q.size(), 0);
        check("wait_flush_access_seen", exp_mem.size(), 0);
        resp_delay = 0;
        do_fetch(32'h0000_0500, 32'h0000_0513);

        // Response timeout on a load
        resp_en = 1'b0;
        do_load(32'h0000_0600, 32'h0, K_BE);
        check("timeout_distance", d_done_cyc - acc_cyc, 4);
        resp_en = 1'b1;

        // Response in the very cycle the counter reaches the limit is accepted
        resp_delay = 3;
        do_load(32'h0000_0700, 32'h0BAD_F00D, K_LD);
        resp_delay = 0;

        // Reset in WAIT_D, then a stray response after release
        resp_en = 1'b0;
        exp_mem.push_back('{addr: 32'h3000, wdata: 32'h0, be: 4'h0, write: 1'b0});
        bus.d_address   = 32'h0000_3000;
        bus.loadRequest = 1'b1;
        repeat (2) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        bus.loadRequest = 1'b0;
        @(negedge clock);
        reset     = 1'b0;
        late_resp = 1'b1;
        @(negedge clock);
        late_resp = 1'b0;
        repeat (4) @(negedge clock);
        check("post_reset_no_pulse", exp_q.size(), 0);
        check("post_reset_idle", bus.m_request, 0);
        check("post_reset_access_seen", exp_mem.size(), 0);
        resp_en = 1'b1;
        do_fetch(32'h0000_0100, 32'h0050_0093);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
